s_axis_rq_arbiter_x8: RTL and testbench

//  Packet-atomic round-robin arbiter that shares the 256-bit RQ request stream between NUM_REQ TLP sources.

---
 rtl/litepcie_rq_arb_pkg.sv | 19 +
 rtl/rq_rr_pick.sv | 34 +++
 rtl/s_axis_rq_arbiter_x8.sv | 135 +++++++++++++
 tb/tb_s_axis_rq_arbiter_x8.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/litepcie_rq_arb_pkg.sv
// Shared types and helpers for the RQ request-stream arbiter.
package litepcie_rq_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  localparam int RQ_DATA_WIDTH = 256;
  localparam int RQ_KEEP_WIDTH = 8;
  localparam int RQ_USER_WIDTH = 60;

  // Sized for the largest supported requester count (8).
  function automatic logic [2:0] onehot2bin(input logic [7:0] oh);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) b = b | 3'(i);
    return b;
  endfunction

endpackage

// File: rtl/rq_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr wins.
module rq_rr_pick
  import litepcie_rq_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    // k == N wraps back onto ptr itself, so the last owner is picked only if alone.
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign idx = IW'(onehot2bin(8'(gnt)));
  assign any = |req;

endmodule

// File: rtl/s_axis_rq_arbiter_x8.sv
// Packet-atomic round-robin arbiter sharing the RQ stream between NUM_REQ sources.
// Define RQ_ARB_PRIO0_EN to give requester 0 strict priority between packets.
module s_axis_rq_arbiter_x8
  import litepcie_rq_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = RQ_DATA_WIDTH,
  parameter int KEEP_WIDTH = RQ_KEEP_WIDTH,
  parameter int USER_WIDTH = RQ_USER_WIDTH
) (
  input  logic                          user_clk,
  input  logic                          user_reset_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_rq_tdata_r,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0] s_axis_rq_tkeep_r,
  input  logic [NUM_REQ*USER_WIDTH-1:0] s_axis_rq_tuser_r,
  input  logic [NUM_REQ-1:0]            s_axis_rq_tlast_r,
  input  logic [NUM_REQ-1:0]            s_axis_rq_tvalid_r,
  output logic [NUM_REQ-1:0]            s_axis_rq_tready_r,
  output logic [DATA_WIDTH-1:0]         m_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_rq_tkeep,
  output logic [USER_WIDTH-1:0]         m_axis_rq_tuser,
  output logic                          m_axis_rq_tlast,
  output logic                          m_axis_rq_tvalid,
  input  logic [3:0]                    m_axis_rq_tready,
  output logic [NUM_REQ-1:0]            arb_grant,
  output logic                          arb_busy
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] tdata_a;
  logic [NUM_REQ-1:0][KEEP_WIDTH-1:0] tkeep_a;
  logic [NUM_REQ-1:0][USER_WIDTH-1:0] tuser_a;

  assign tdata_a = s_axis_rq_tdata_r;
  assign tkeep_a = s_axis_rq_tkeep_r;
  assign tuser_a = s_axis_rq_tuser_r;

  state_t             state, state_nxt;
  logic [IW-1:0]      owner, rr_ptr, sel, idle_sel, pick_idx;
  logic [NUM_REQ-1:0] pick_req, pick_gnt, idle_oh, sel_oh;
  logic               pick_any, idle_any, sel_en, slot_free, accept, sel_last, rr_upd;
  logic               unused_tready;

  assign unused_tready = ^m_axis_rq_tready[3:1];

  rq_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (pick_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef RQ_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the picker only sees 1..N-1.
  assign pick_req = s_axis_rq_tvalid_r & ~NUM_REQ'(1);
  assign idle_oh  = s_axis_rq_tvalid_r[0] ? NUM_REQ'(1) : pick_gnt;
  assign idle_sel = s_axis_rq_tvalid_r[0] ? '0 : pick_idx;
  assign idle_any = s_axis_rq_tvalid_r[0] | pick_any;
  assign rr_upd   = (sel != '0);
`else
  assign pick_req = s_axis_rq_tvalid_r;
  assign idle_oh  = pick_gnt;
  assign idle_sel = pick_idx;
  assign idle_any = pick_any;
  assign rr_upd   = 1'b1;
`endif

  always_comb begin
    sel    = idle_sel;
    sel_en = idle_any;
    sel_oh = idle_oh;
    if (state == ST_PKT) begin
      sel    = owner;
      sel_en = 1'b1;
      sel_oh = NUM_REQ'(1) << owner;
    end
  end

  assign slot_free          = !m_axis_rq_tvalid | m_axis_rq_tready[0];
  assign accept             = slot_free & sel_en & s_axis_rq_tvalid_r[sel];
  assign sel_last           = s_axis_rq_tlast_r[sel];
  assign s_axis_rq_tready_r = (slot_free & sel_en) ? sel_oh : '0;
  assign arb_busy           = (state == ST_PKT);

  always_ff @(posedge user_clk or negedge user_reset_n)
    if (!user_reset_n) state <= ST_IDLE;
    else               state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !sel_last) state_nxt = ST_PKT;
      ST_PKT:  if (accept &&  sel_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Owner, rotation pointer and reported grant move only on accepted beats.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      owner     <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      arb_grant <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        arb_grant <= sel_oh;
        owner     <= sel;
        if (sel_last && rr_upd) rr_ptr <= sel;
      end else if (sel_last && rr_upd) begin
        rr_ptr <= owner;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      m_axis_rq_tvalid <= 1'b0;
      m_axis_rq_tlast  <= 1'b0;
      m_axis_rq_tdata  <= '0;
      m_axis_rq_tkeep  <= '0;
      m_axis_rq_tuser  <= '0;
    end else if (accept) begin
      m_axis_rq_tvalid <= 1'b1;
      m_axis_rq_tlast  <= sel_last;
      m_axis_rq_tdata  <= tdata_a[sel];
      m_axis_rq_tkeep  <= tkeep_a[sel];
      m_axis_rq_tuser  <= tuser_a[sel];
    end else if (slot_free) begin
      m_axis_rq_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s_axis_rq_arbiter_x8.sv
// Scoreboard bench for s_axis_rq_arbiter_x8; honours RQ_ARB_PRIO0_EN when defined.
module tb_s_axis_rq_arbiter_x8;

  localparam int N = 3, DW = 256, KW = 8, UW = 60;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic [N-1:0]  gnt;
  } beat_t;

  logic              user_clk, user_reset_n;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N*UW-1:0]   s_tuser;
  logic [N-1:0]      s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tlast, m_tvalid;
  logic [3:0]        m_tready;
  logic [N-1:0]      arb_grant;
  logic              arb_busy;

  s_axis_rq_arbiter_x8 #(.NUM_REQ(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .user_clk           (user_clk),
    .user_reset_n       (user_reset_n),
    .s_axis_rq_tdata_r  (s_tdata),
    .s_axis_rq_tkeep_r  (s_tkeep),
    .s_axis_rq_tuser_r  (s_tuser),
    .s_axis_rq_tlast_r  (s_tlast),
    .s_axis_rq_tvalid_r (s_tvalid),
    .s_axis_rq_tready_r (s_tready),
    .m_axis_rq_tdata    (m_tdata),
    .m_axis_rq_tkeep    (m_tkeep),
    .m_axis_rq_tuser    (m_tuser),
    .m_axis_rq_tlast    (m_tlast),
    .m_axis_rq_tvalid   (m_tvalid),
    .m_axis_rq_tready   (m_tready),
    .arb_grant          (arb_grant),
    .arb_busy           (arb_busy)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  beat_t     srcq [N][$];
  beat_t     exp_q[$];
  logic [N-1:0] hs, hold;
  logic      rdy;
  int        nchk, nfail;

  function automatic beat_t mk(int id, int tag, logic last);
    beat_t b;
    b.data = {8'hA5, {232{1'b0}}, 8'(id), 8'(tag)};
    b.keep = 8'(tag * 3 + id);
    b.user = {8'(id), 8'(tag), 44'h0CAFEF00D12};
    b.last = last;
    b.gnt  = N'(1 << id);
    return b;
  endfunction

  task automatic send(int id, int tag, int nb);
    for (int k = 0; k < nb; k++) srcq[id].push_back(mk(id, tag + k, k == nb - 1));
  endtask

  task automatic exp_pkt(int id, int tag, int nb);
    for (int k = 0; k < nb; k++) exp_q.push_back(mk(id, tag + k, k == nb - 1));
  endtask

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] want);
    nchk++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // One cycle of source/sink driving; beats handshaken on the last edge are retired first.
  task automatic step();
    beat_t b;
    @(negedge user_clk);
    for (int i = 0; i < N; i++) if (hs[i]) void'(srcq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() != 0 && !hold[i]) begin
        b = srcq[i][0];
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = b.data;
        s_tkeep[i*KW +: KW]  = b.keep;
        s_tuser[i*UW +: UW]  = b.user;
        s_tlast[i]           = b.last;
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    m_tready = rdy ? 4'hF : 4'hE;
    #1;
    hs = s_tvalid & s_tready;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() != 0 || exp_q.size() != 0 || m_tvalid)
           && n < 300) begin
      step();
      n++;
    end
    nchk++;
    if (n >= 300) begin
      nfail++;
      $display("FAIL %s_drain: timeout, %0d expected beats outstanding", nm, exp_q.size());
    end
  endtask

  // Monitor: samples settled outputs each cycle, pops the scoreboard on every output handshake.
  initial begin
    beat_t         e;
    logic          prev_stall;
    logic [DW-1:0] pd;
    logic          pl;
    prev_stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge user_clk);
      #2;
      if (prev_stall) begin
        nchk++;
        if (m_tdata !== pd || m_tlast !== pl || !m_tvalid) begin
          nfail++;
          $display("FAIL stall_hold: got data %0h last %b want data %0h last %b", m_tdata, m_tlast, pd, pl);
        end
      end
      nchk++;
      if ($countones(s_tready) > 1) begin
        nfail++;
        $display("FAIL tready_onehot: got %b want one-hot or zero", s_tready);
      end
      if (m_tvalid && m_tready[0]) begin
        nchk++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL out_beat: got unexpected beat %0h want none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tkeep !== e.keep || m_tuser !== e.user ||
              m_tlast !== e.last || arb_grant !== e.gnt) begin
            nfail++;
            $display("FAIL out_beat: got data %0h last %b grant %b want data %0h last %b grant %b",
                     m_tdata, m_tlast, arb_grant, e.data, e.last, e.gnt);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready[0];
      pd = m_tdata;
      pl = m_tlast;
    end
  end

  initial begin
    nchk = 0; nfail = 0;
    hs = '0; hold = '0; rdy = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0; s_tvalid = '0;
    m_tready = 4'hF;
    user_reset_n = 1'b0;
    @(negedge user_clk);
    @(negedge user_clk);
    chk("rst_tvalid", DW'(m_tvalid), DW'(0));
    chk("rst_tlast",  DW'(m_tlast),  DW'(0));
    chk("rst_tdata",  m_tdata,       DW'(0));
    chk("rst_grant",  DW'(arb_grant), DW'(0));
    chk("rst_busy",   DW'(arb_busy), DW'(0));
    user_reset_n = 1'b1;

    // T1: continuous single-beat TLPs from all requesters
    send(0, 0, 1); send(0, 1, 1);
    send(1, 10, 1); send(1, 11, 1);
    send(2, 20, 1); send(2, 21, 1);
`ifdef RQ_ARB_PRIO0_EN
    exp_pkt(0, 0, 1); exp_pkt(0, 1, 1); exp_pkt(1, 10, 1);
    exp_pkt(2, 20, 1); exp_pkt(1, 11, 1); exp_pkt(2, 21, 1);
`else
    exp_pkt(0, 0, 1); exp_pkt(1, 10, 1); exp_pkt(2, 20, 1);
    exp_pkt(0, 1, 1); exp_pkt(1, 11, 1); exp_pkt(2, 21, 1);
`endif
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_tvalid_cont", DW'(m_tvalid), DW'(1));
    end
    drain("t1");

    // T2: req1 4-beat TLP locked against req0/req2
    send(0, 30, 1); send(1, 40, 4); send(2, 50, 1);
    exp_pkt(0, 30, 1); exp_pkt(1, 40, 4); exp_pkt(2, 50, 1);
    step(); step(); step();
    chk("t2_busy", DW'(arb_busy), DW'(1));
    drain("t2");

    // T3: output stalls 1,0,0,1 in mid-packet
    send(0, 60, 4);
    exp_pkt(0, 60, 4);
    rdy = 1'b1; step(); step();
    rdy = 1'b0; step(); step();
    rdy = 1'b1;
    drain("t3");

    // T4: owner gaps 3 cycles while req0 waits
    send(1, 70, 4);
    exp_pkt(1, 70, 4);
    step();
    send(0, 80, 1);
    exp_pkt(0, 80, 1);
    step();
    hold[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_req0_tready", DW'(s_tready[0]), DW'(0));
      chk("t4_busy", DW'(arb_busy), DW'(1));
    end
    hold[1] = 1'b0;
    drain("t4");

    // T5: reset while beat 2 of a 3-beat TLP is offered
    send(1, 90, 3);
    exp_q.push_back(mk(1, 90, 1'b0));
    step(); step();
    #2;
    chk("t5_pre_reset_beats", DW'(exp_q.size()), DW'(0));
    user_reset_n = 1'b0;
    s_tvalid = '0;
    hold = '0; hs = '0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    exp_q.delete();
    #1;
    chk("t5_rst_tvalid", DW'(m_tvalid), DW'(0));
    chk("t5_rst_tdata",  m_tdata,       DW'(0));
    chk("t5_rst_grant",  DW'(arb_grant), DW'(0));
    chk("t5_rst_busy",   DW'(arb_busy), DW'(0));
    @(negedge user_clk);
    @(negedge user_clk);
    user_reset_n = 1'b1;
    send(0, 100, 1); send(1, 101, 1); send(2, 102, 1);
    exp_pkt(0, 100, 1); exp_pkt(1, 101, 1); exp_pkt(2, 102, 1);
    drain("t5");

`ifdef RQ_ARB_PRIO0_EN
    // T6: requester 0 strict priority, then 1/2 alternate
    send(0, 110, 1); send(0, 111, 1); send(0, 112, 1);
    send(1, 120, 1); send(1, 121, 1);
    send(2, 130, 1); send(2, 131, 1);
    exp_pkt(0, 110, 1); exp_pkt(0, 111, 1); exp_pkt(0, 112, 1);
    exp_pkt(1, 120, 1); exp_pkt(2, 130, 1); exp_pkt(1, 121, 1); exp_pkt(2, 131, 1);
    drain("t6");
`endif

    @(negedge user_clk);
    @(negedge user_clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
